regfile_wb_arbiter: RTL and testbench

Write-back arbiter and pending-write scoreboard for the 32x32 register file in the multi-cycle RISC-V core. Two write-back sources (ALU/CSR result path and load unit) share the register file's single write port through a round-robin valid/ready handshake. One registered stage drives the write port. A 32-bit pending mask tracks destinations issued but not yet written, so the control FSM can stall on RAW and WAW hazards.

---
 rtl/regfile_wb_arbiter_if.sv | 52 +++++
 rtl/regfile_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the write-back sources, the control FSM and the register-file
// write-back arbiter. The master modport is the core side; the slave modport is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_rd;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_rd;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_ready;

  logic [ADDR_W-1:0] chk_rs1;
  logic [ADDR_W-1:0] chk_rs2;
  logic              hazard;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output req0_valid, req0_rd, req0_data,
    input  req0_ready,
    output req1_valid, req1_rd, req1_data,
    input  req1_ready,
    output issue_valid, issue_rd,
    input  issue_ready,
    output chk_rs1, chk_rs2,
    input  hazard,
    input  rf_we, rf_rd, rf_wdata
  );

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    output req0_ready,
    input  req1_valid, req1_rd, req1_data,
    output req1_ready,
    input  issue_valid, issue_rd,
    output issue_ready,
    input  chk_rs1, chk_rs2,
    output hazard,
    output rf_we, rf_rd, rf_wdata
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and pending-write scoreboard for the register file's single write port.
// Define RF_ARB_FIXED_PRIO_EN for fixed priority (load unit wins ties) instead of round-robin.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_wb_arbiter_if.slave   bus
);
  localparam int NREG = 1 << ADDR_W;

`ifndef RF_ARB_FIXED_PRIO_EN
  typedef enum logic {SRC0 = 1'b0, SRC1 = 1'b1} src_e;
  src_e last_q, last_d;
`endif

  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]   pending_q, pending_d;

  logic              issue_ok;
  logic              issue_fire;
  logic              rs1_hit;
  logic              rs2_hit;

  // Grants are suppressed during reset so nothing is accepted while rst_n is low.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      if (bus.req0_valid && bus.req1_valid) begin
`ifdef RF_ARB_FIXED_PRIO_EN
        grant1 = 1'b1;
`else
        grant0 = (last_q == SRC1);
        grant1 = (last_q == SRC0);
`endif
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign xfer     = grant0 | grant1;
  assign sel_rd   = grant1 ? bus.req1_rd   : bus.req0_rd;
  assign sel_data = grant1 ? bus.req1_data : bus.req0_data;

`ifndef RF_ARB_FIXED_PRIO_EN
  always_comb begin
    last_d = last_q;
    if (grant0) begin
      last_d = SRC0;
    end else if (grant1) begin
      last_d = SRC1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= SRC1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // x0 writes load the index/data but never raise the write enable.
  always_comb begin
    rf_we_d    = xfer && (sel_rd != '0);
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (xfer) begin
      rf_rd_d    = sel_rd;
      rf_wdata_d = sel_data;
    end
  end

  assign issue_ok   = rst_n && !((bus.issue_rd != '0) && pending_q[bus.issue_rd]);
  assign issue_fire = bus.issue_valid && issue_ok;

  // Set is applied after clear so a same-cycle issue of the retiring register keeps it pending.
  always_comb begin
    pending_d = pending_q;
    if (rf_we_q) begin
      pending_d[rf_rd_q] = 1'b0;
    end
    if (issue_fire && (bus.issue_rd != '0)) begin
      pending_d[bus.issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      pending_q  <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      pending_q  <= pending_d;
    end
  end

  assign rs1_hit = (bus.chk_rs1 != '0) && pending_q[bus.chk_rs1];
  assign rs2_hit = (bus.chk_rs2 != '0) && pending_q[bus.chk_rs2];

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.issue_ready = issue_ok;
  assign bus.hazard      = rs1_hit || rs2_hit;
  // Gating with rst_n drops a write that is in flight when reset arrives.
  assign bus.rf_we       = rf_we_q && rst_n;
  assign bus.rf_rd       = rf_rd_q;
  assign bus.rf_wdata    = rf_wdata_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus pushes expected register-file writes,
// a negedge monitor pops and compares them whenever rf_we is presented.
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  wr_t exp_q[$];
  wr_t mon_e;
  int  pass_cnt = 0;
  int  total_cnt = 0;
  int  exp_g[4];

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive_req(input int src, input logic v, input logic [ADDR_W-1:0] rd,
                           input logic [DATA_W-1:0] data);
    if (src == 0) begin
      bus.req0_valid = v;
      bus.req0_rd    = rd;
      bus.req0_data  = data;
    end else begin
      bus.req1_valid = v;
      bus.req1_rd    = rd;
      bus.req1_data  = data;
    end
  endtask

  task automatic drive_issue(input logic v, input logic [ADDR_W-1:0] rd);
    bus.issue_valid = v;
    bus.issue_rd    = rd;
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
    wr_t w;
    w.rd   = rd;
    w.data = data;
    exp_q.push_back(w);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Every presented write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.rf_we === 1'b1) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL wb_unexpected: got rd=%0d data=0x%0h, expected no write",
                 bus.rf_rd, bus.rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.rf_rd === mon_e.rd && bus.rf_wdata === mon_e.data) begin
          pass_cnt++;
        end else begin
          $display("[TB] FAIL wb_write: got rd=%0d data=0x%0h, expected rd=%0d data=0x%0h",
                   bus.rf_rd, bus.rf_wdata, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef RF_ARB_FIXED_PRIO_EN
    exp_g = '{1, 1, 1, 1};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    drive_req(0, 1'b0, '0, '0);
    drive_req(1, 1'b0, '0, '0);
    drive_issue(1'b0, '0);
    bus.chk_rs1 = '0;
    bus.chk_rs2 = '0;

    // Reset with activity on every input
    rst_n = 1'b0;
    drive_req(0, 1'b1, 5'd2, 32'h0000_2222);
    drive_req(1, 1'b1, 5'd12, 32'h0000_1212);
    drive_issue(1'b1, 5'd5);
    bus.chk_rs1 = 5'd5;
    repeat (2) next_cycle();
    settle();
    check_output("rst_rf_we", 32'(bus.rf_we), 0);
    check_output("rst_rf_rd", 32'(bus.rf_rd), 0);
    check_output("rst_rf_wdata", bus.rf_wdata, 0);
    check_output("rst_ready0", 32'(bus.req0_ready), 0);
    check_output("rst_ready1", 32'(bus.req1_ready), 0);
    check_output("rst_issue_ready", 32'(bus.issue_ready), 0);
    next_cycle();
    rst_n = 1'b1;
    drive_req(0, 1'b0, '0, '0);
    drive_req(1, 1'b0, '0, '0);
    drive_issue(1'b0, '0);
    settle();
    check_output("rst_hazard", 32'(bus.hazard), 0);

    // Tie arbitration, each source advances only when granted
    begin
      int i0 = 0;
      int i1 = 0;
      for (int c = 0; c < 4; c++) begin
        next_cycle();
        drive_req(0, 1'b1, ADDR_W'(1 + i0), 32'hA000_0000 + 32'(1 + i0));
        drive_req(1, 1'b1, ADDR_W'(11 + i1), 32'hB000_0000 + 32'(11 + i1));
        if (exp_g[c] == 0) push_exp(ADDR_W'(1 + i0), 32'hA000_0000 + 32'(1 + i0));
        else               push_exp(ADDR_W'(11 + i1), 32'hB000_0000 + 32'(11 + i1));
        settle();
        check_output("tie_ready0", 32'(bus.req0_ready), 32'(exp_g[c] == 0));
        check_output("tie_ready1", 32'(bus.req1_ready), 32'(exp_g[c] == 1));
        if (exp_g[c] == 0) i0++;
        else               i1++;
      end
    end
    next_cycle();
    drive_req(0, 1'b0, '0, '0);
    drive_req(1, 1'b0, '0, '0);
    settle();

    // Single write with hazard window
    next_cycle();
    drive_issue(1'b1, 5'd7);
    settle();
    check_output("sw_issue_ready", 32'(bus.issue_ready), 1);
    next_cycle();
    drive_issue(1'b0, '0);
    bus.chk_rs1 = 5'd7;
    drive_req(0, 1'b1, 5'd7, 32'hDEAD_BEEF);
    push_exp(5'd7, 32'hDEAD_BEEF);
    settle();
    check_output("sw_hazard_pre", 32'(bus.hazard), 1);
    check_output("sw_ready0", 32'(bus.req0_ready), 1);
    next_cycle();
    drive_req(0, 1'b0, '0, '0);
    settle();
    check_output("sw_hazard_wb", 32'(bus.hazard), 1);
    check_output("sw_rf_we", 32'(bus.rf_we), 1);
    next_cycle();
    settle();
    check_output("sw_hazard_post", 32'(bus.hazard), 0);

    // x0 request and x0 issue
    next_cycle();
    drive_req(1, 1'b1, 5'd0, 32'h0000_1234);
    settle();
    check_output("x0_ready1", 32'(bus.req1_ready), 1);
    next_cycle();
    drive_req(1, 1'b0, '0, '0);
    drive_issue(1'b1, 5'd0);
    settle();
    check_output("x0_rf_we", 32'(bus.rf_we), 0);
    check_output("x0_issue_ready", 32'(bus.issue_ready), 1);
    next_cycle();
    drive_issue(1'b0, '0);
    settle();
    check_output("x0_hazard", 32'(bus.hazard), 0);

    // WAW stall, then set-wins against a same-cycle clear
    next_cycle();
    drive_issue(1'b1, 5'd9);
    bus.chk_rs1 = '0;
    bus.chk_rs2 = 5'd9;
    settle();
    check_output("waw_first_ready", 32'(bus.issue_ready), 1);
    next_cycle();
    settle();
    check_output("waw_stall", 32'(bus.issue_ready), 0);
    check_output("waw_hazard", 32'(bus.hazard), 1);
    next_cycle();
    drive_issue(1'b0, '0);
    drive_req(0, 1'b1, 5'd9, 32'h0000_0099);
    push_exp(5'd9, 32'h0000_0099);
    settle();
    check_output("waw_ready0", 32'(bus.req0_ready), 1);
    next_cycle();
    drive_req(0, 1'b1, 5'd9, 32'h0000_0199);
    push_exp(5'd9, 32'h0000_0199);
    settle();
    check_output("waw_hazard_wb", 32'(bus.hazard), 1);
    next_cycle();
    drive_req(0, 1'b0, '0, '0);
    drive_issue(1'b1, 5'd9);
    settle();
    check_output("sw9_issue_ready", 32'(bus.issue_ready), 1);
    check_output("sw9_hazard_clear", 32'(bus.hazard), 0);
    next_cycle();
    drive_issue(1'b0, 5'd9);
    settle();
    check_output("set_wins_hazard", 32'(bus.hazard), 1);
    check_output("set_wins_issue", 32'(bus.issue_ready), 0);

    // Reset arriving while a write is in flight
    next_cycle();
    drive_issue(1'b1, 5'd3);
    bus.chk_rs1 = 5'd3;
    bus.chk_rs2 = '0;
    settle();
    check_output("rm_issue_ready", 32'(bus.issue_ready), 1);
    next_cycle();
    drive_issue(1'b0, '0);
    drive_req(0, 1'b1, 5'd3, 32'h0000_0033);
    settle();
    check_output("rm_ready0", 32'(bus.req0_ready), 1);
    check_output("rm_hazard_pre", 32'(bus.hazard), 1);
    next_cycle();
    rst_n = 1'b0;
    drive_req(0, 1'b0, '0, '0);
    settle();
    check_output("rm_rf_we_dropped", 32'(bus.rf_we), 0);
    next_cycle();
    rst_n = 1'b1;
    drive_issue(1'b0, 5'd3);
    settle();
    check_output("rm_hazard_post", 32'(bus.hazard), 0);
    check_output("rm_issue_ready3", 32'(bus.issue_ready), 1);
    check_output("rm_rf_rd", 32'(bus.rf_rd), 0);
    check_output("rm_rf_wdata", bus.rf_wdata, 0);

    repeat (2) next_cycle();
    settle();
    check_output("sb_drain", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
